mirror_display_scan: RTL and testbench
======================================

Name: mirror_display_scan

Overview:
- Parametrised successor to the 4-way mirror-display selector.
- Takes NCH sensor channels of WIDTH bits each and drives a single registered mirror display.
- Three display modes:
  - manual selection;
  - timed auto-scroll that skips invalid channels;
  - priority low-value alert override on one designated channel (e.g. miles remaining).
- Sits between the sensor-conditioning blocks and the mirror display driver.

Parameters:
- WIDTH, 8, bits per channel and display width.
- NCH, 4, number of channels (2..16).
- SEL_W, 2, select/pointer width; must satisfy 2**SEL_W >= NCH.
- DWELL_CYCLES, 50000000, clock cycles each channel is shown in auto-scroll (>=2).
- ALERT_CH, 3, channel index monitored for alert.
- ALERT_FILTER, 4, consecutive below-threshold cycles needed to raise alert (>=1).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- ch_data  in  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- ch_valid  in  NCH  per-channel data-valid flag.
- auto_mode  in  1  0 = manual, 1 = auto-scroll.
- sel_manual  in  SEL_W  channel select in manual mode.
- next_pulse  in  1  single-cycle request to advance; honoured in auto mode only.
- alert_thresh  in  WIDTH  unsigned alert threshold.
- display  out  WIDTH  registered display value.
- disp_ch  out  SEL_W  channel index currently shown.
- disp_valid  out  1  display holds valid data.
- alert  out  1  alert override active.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: display=0, disp_ch=0, disp_valid=0, alert=0. Internally: state=MANUAL, ptr=0, dwell=0, filter count=0.
- Output timing: all outputs are registered. display, disp_ch and disp_valid reflect the inputs and state of the previous edge, i.e. 1-cycle latency.
- State MANUAL (auto_mode=0):
  - ptr <= sel_manual.
  - If sel_manual >= NCH: display=0, disp_valid=0, disp_ch=sel_manual.
  - Otherwise display=ch_data[sel], disp_valid=ch_valid[sel].
  - dwell is held at 0.
- State SCROLL (auto_mode=1):
  - dwell increments each cycle.
  - Advance occurs when dwell==DWELL_CYCLES-1 or next_pulse=1. On advance, dwell <= 0.
  - ptr moves to the next index with ch_valid=1, searching ptr+1 … NCH-1, then wrapping to 0 … ptr.
  - If no channel is valid, ptr is unchanged and disp_valid=0.
  - display always shows ch_data[ptr]; disp_valid=ch_valid[ptr].
- Mode switch:
  - MANUAL->SCROLL: ptr starts from the last manual select (forced to 0 if >= NCH); dwell=0.
  - SCROLL->MANUAL: takes effect on the next edge.
- Alert filter:
  - Count increments while ch_valid[ALERT_CH]=1 and ch_data[ALERT_CH] < alert_thresh, saturating at ALERT_FILTER.
  - Count clears on any cycle where that condition is false.
- Entering ALERT: from either state when the filter count reaches ALERT_FILTER; alert=1 on the same edge the count saturates.
- In ALERT:
  - display=ch_data[ALERT_CH], disp_ch=ALERT_CH, disp_valid=1.
  - dwell is held at 0; next_pulse and sel_manual are ignored; ptr is preserved.
- Leaving ALERT: on the first cycle the condition is false (value >= thresh or channel invalid). Return to MANUAL or SCROLL per auto_mode, resuming at the preserved ptr with dwell=0; alert=0.
- Priorities:
  - alert > next_pulse > dwell expiry.
  - next_pulse coinciding with dwell expiry advances once only.
  - next_pulse in MANUAL is ignored.
- Comparison and data: unsigned; equality with the threshold is not an alert. ch_data is not latched; display tracks live data every cycle.
- rst asserted mid-scroll or mid-alert returns every register to its reset value on that edge.

Test Plan:
- Bench params: DWELL_CYCLES=4, ALERT_FILTER=2.
- Reset/manual: rst 2 cycles, then auto_mode=0, sel_manual=2, ch2=0x37, valid=4'hF -> 1 cycle later display=0x37, disp_ch=2, disp_valid=1; during rst all outputs are 0.
- Auto-scroll with skip/wrap: auto_mode=1, ptr=0, ch_valid=4'b1011 -> disp_ch sequence 0,1,3,0 with exactly 4 cycles per channel; channel 2 is never shown.
- next_pulse: in SCROLL at dwell=1 on ch0, pulse 1 cycle -> disp_ch=1 next cycle, then held 4 full cycles; a pulse coincident with expiry advances by 1, not 2.
- Alert override: alert_thresh=0x10, ch3 drops to 0x0C while scrolling on ch1 -> alert=1 after 2 cycles, display=0x0C, disp_ch=3. Then ch3=0x10 -> alert=0 next edge, display resumes ch1 with a fresh 4-cycle dwell. A single-cycle dip to 0x0C raises no alert.
- Boundaries:
  - ch_valid=0 in SCROLL -> disp_valid=0, ptr frozen.
  - NCH=3 build with sel_manual=3 -> display=0, disp_valid=0.
  - rst asserted during ALERT -> alert=0, display=0 on that edge.

Source files
------------

// File: rtl/mirror_display_scan.sv
// Mirror-display channel selector: manual select, timed auto-scroll over valid
// channels, and a filtered low-value alert override on one channel.
module mirror_display_scan #(
  parameter int WIDTH        = 8,
  parameter int NCH          = 4,
  parameter int SEL_W        = 2,
  parameter int DWELL_CYCLES = 50000000,
  parameter int ALERT_CH     = 3,
  parameter int ALERT_FILTER = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*WIDTH-1:0] ch_data,
  input  logic [NCH-1:0]       ch_valid,
  input  logic                 auto_mode,
  input  logic [SEL_W-1:0]     sel_manual,
  input  logic                 next_pulse,
  input  logic [WIDTH-1:0]     alert_thresh,
  output logic [WIDTH-1:0]     display,
  output logic [SEL_W-1:0]     disp_ch,
  output logic                 disp_valid,
  output logic                 alert
);

  localparam int DW_W  = $clog2(DWELL_CYCLES);
  localparam int CNT_W = $clog2(ALERT_FILTER + 1);

  localparam logic [1:0] ST_MANUAL = 2'd0;
  localparam logic [1:0] ST_SCROLL = 2'd1;
  localparam logic [1:0] ST_ALERT  = 2'd2;

  logic [1:0]       state, state_n;
  logic [SEL_W-1:0] ptr, ptr_n;
  logic [DW_W-1:0]  dwell, dwell_n;
  logic [CNT_W-1:0] cnt, cnt_n;

  logic [WIDTH-1:0] alert_val;
  logic             alert_cond, alert_n;
  logic [SEL_W-1:0] adv_ptr, hi_idx, lo_idx;
  logic             hi_found, lo_found;
  logic [WIDTH-1:0] disp_n;
  logic [SEL_W-1:0] ch_n;
  logic             vld_n;

  function automatic logic [WIDTH-1:0] pick_data(input logic [NCH*WIDTH-1:0] d,
                                                 input logic [SEL_W-1:0] idx);
    pick_data = '0;
    for (int unsigned k = 0; k < NCH; k++)
      if (32'(idx) == k) pick_data = d[k*WIDTH +: WIDTH];
  endfunction

  function automatic logic pick_valid(input logic [NCH-1:0] v,
                                      input logic [SEL_W-1:0] idx);
    pick_valid = 1'b0;
    for (int unsigned k = 0; k < NCH; k++)
      if (32'(idx) == k) pick_valid = v[k];
  endfunction

  assign alert_val  = ch_data[ALERT_CH*WIDTH +: WIDTH];
  assign alert_cond = ch_valid[ALERT_CH] && (alert_val < alert_thresh);

  always_comb begin
    if (!alert_cond)
      cnt_n = '0;
    else if (cnt == CNT_W'(ALERT_FILTER))
      cnt_n = cnt;
    else
      cnt_n = cnt + CNT_W'(1);
    alert_n = (cnt_n == CNT_W'(ALERT_FILTER));
  end

  // Next valid channel: first valid above ptr, else first valid at or below
  // ptr (the wrap), else stay put.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int unsigned j = 0; j < NCH; j++) begin
      if (!hi_found && ch_valid[j] && (j > 32'(ptr))) begin
        hi_found = 1'b1;
        hi_idx   = SEL_W'(j);
      end
      if (!lo_found && ch_valid[j] && (j <= 32'(ptr))) begin
        lo_found = 1'b1;
        lo_idx   = SEL_W'(j);
      end
    end
    if (hi_found)
      adv_ptr = hi_idx;
    else if (lo_found)
      adv_ptr = lo_idx;
    else
      adv_ptr = ptr;
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    dwell_n = '0;
    if (alert_n) begin
      state_n = ST_ALERT;
    end else if (!auto_mode) begin
      state_n = ST_MANUAL;
      ptr_n   = sel_manual;
    end else if (state != ST_SCROLL) begin
      // Entering scroll from manual or alert restarts the dwell at this ptr.
      state_n = ST_SCROLL;
      ptr_n   = (32'(ptr) >= NCH) ? '0 : ptr;
    end else if (next_pulse || (dwell == DW_W'(DWELL_CYCLES - 1))) begin
      ptr_n = adv_ptr;
    end else begin
      dwell_n = dwell + DW_W'(1);
    end
  end

  always_comb begin
    if (alert_n) begin
      disp_n = alert_val;
      ch_n   = SEL_W'(ALERT_CH);
      vld_n  = 1'b1;
    end else begin
      disp_n = pick_data(ch_data, ptr_n);
      ch_n   = ptr_n;
      vld_n  = pick_valid(ch_valid, ptr_n);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_MANUAL;
      ptr        <= '0;
      dwell      <= '0;
      cnt        <= '0;
      display    <= '0;
      disp_ch    <= '0;
      disp_valid <= 1'b0;
      alert      <= 1'b0;
    end else begin
      state      <= state_n;
      ptr        <= ptr_n;
      dwell      <= dwell_n;
      cnt        <= cnt_n;
      display    <= disp_n;
      disp_ch    <= ch_n;
      disp_valid <= vld_n;
      alert      <= alert_n;
    end
  end

endmodule

// File: tb/tb_mirror_display_scan.sv
// Scoreboard bench for mirror_display_scan: a 4-channel and a 3-channel build
// share stimulus; a behavioural model predicts each registered output.
module tb_mirror_display_scan;

  localparam int DWELL        = 4;
  localparam int ALERT_FILTER = 2;
  localparam int MD_MAN = 0, MD_SCR = 1, MD_ALR = 2;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] ch;
    logic       v;
    logic       a;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ch_data = '0;
  logic [3:0]  ch_valid = '0;
  logic        auto_mode = 1'b0;
  logic [1:0]  sel_manual = '0;
  logic        next_pulse = 1'b0;
  logic [7:0]  alert_thresh = 8'h10;

  logic [7:0] d4, d3;
  logic [1:0] c4, c3;
  logic       v4, v3, a4, a3;

  int n_checks = 0;
  int n_err    = 0;

  int m_mode[2], m_ptr[2], m_dwell[2], m_cnt[2];
  exp_t q4[$], q3[$];

  always #5 clk = ~clk;

  mirror_display_scan #(.WIDTH(8), .NCH(4), .SEL_W(2), .DWELL_CYCLES(DWELL),
                        .ALERT_CH(3), .ALERT_FILTER(ALERT_FILTER)) u4 (
    .clk(clk), .rst(rst), .ch_data(ch_data), .ch_valid(ch_valid),
    .auto_mode(auto_mode), .sel_manual(sel_manual), .next_pulse(next_pulse),
    .alert_thresh(alert_thresh), .display(d4), .disp_ch(c4),
    .disp_valid(v4), .alert(a4));

  mirror_display_scan #(.WIDTH(8), .NCH(3), .SEL_W(2), .DWELL_CYCLES(DWELL),
                        .ALERT_CH(2), .ALERT_FILTER(ALERT_FILTER)) u3 (
    .clk(clk), .rst(rst), .ch_data(ch_data[23:0]), .ch_valid(ch_valid[2:0]),
    .auto_mode(auto_mode), .sel_manual(sel_manual), .next_pulse(next_pulse),
    .alert_thresh(alert_thresh), .display(d3), .disp_ch(c3),
    .disp_valid(v3), .alert(a3));

  function automatic int byte_of(input logic [31:0] d, input int k);
    return int'((d >> (8 * k)) & 32'hFF);
  endfunction

  // Per-edge reference: what the display shows after an edge with these inputs.
  function automatic exp_t model_step(input int i, input int nch, input int ach,
                                      input bit r, input bit am, input int sel,
                                      input bit np, input int thr,
                                      input logic [3:0] val, input logic [31:0] dat);
    exp_t e;
    bit   cond;
    int   nxt;
    e = '0;
    if (r) begin
      m_mode[i] = MD_MAN; m_ptr[i] = 0; m_dwell[i] = 0; m_cnt[i] = 0;
      return e;
    end
    cond = val[ach] && (byte_of(dat, ach) < thr);
    if (!cond) m_cnt[i] = 0;
    else if (m_cnt[i] < ALERT_FILTER) m_cnt[i]++;
    if (m_cnt[i] == ALERT_FILTER) begin
      m_mode[i] = MD_ALR; m_dwell[i] = 0;
      e.d = 8'(byte_of(dat, ach)); e.ch = 2'(ach); e.v = 1'b1; e.a = 1'b1;
      return e;
    end
    if (!am) begin
      m_mode[i] = MD_MAN; m_ptr[i] = sel; m_dwell[i] = 0;
      e.ch = 2'(sel);
      if (sel < nch) begin
        e.d = 8'(byte_of(dat, sel)); e.v = val[sel];
      end
      return e;
    end
    if (m_mode[i] != MD_SCR) begin
      m_mode[i] = MD_SCR; m_dwell[i] = 0;
      if (m_ptr[i] >= nch) m_ptr[i] = 0;
    end else if (np || m_dwell[i] == DWELL - 1) begin
      m_dwell[i] = 0;
      for (int k = 1; k <= nch; k++) begin
        nxt = (m_ptr[i] + k) % nch;
        if (val[nxt]) begin
          m_ptr[i] = nxt;
          break;
        end
      end
    end else begin
      m_dwell[i]++;
    end
    e.ch = 2'(m_ptr[i]); e.d = 8'(byte_of(dat, m_ptr[i])); e.v = val[m_ptr[i]];
    return e;
  endfunction

  task automatic cmp(input string name, input exp_t got, input exp_t e);
    n_checks++;
    if (got !== e) begin
      n_err++;
      $display("FAIL %s t=%0t got d=%h ch=%0d v=%b a=%b required d=%h ch=%0d v=%b a=%b",
               name, $time, got.d, got.ch, got.v, got.a, e.d, e.ch, e.v, e.a);
    end
  endtask

  task automatic drive(input bit r, input bit am, input int sel, input bit np,
                       input int thr, input logic [3:0] val, input logic [31:0] dat);
    @(negedge clk);
    rst = r; auto_mode = am; sel_manual = 2'(sel); next_pulse = np;
    alert_thresh = 8'(thr); ch_valid = val; ch_data = dat;
    q4.push_back(model_step(0, 4, 3, r, am, sel, np, thr, val, dat));
    q3.push_back(model_step(1, 3, 2, r, am, sel, np, thr, val, dat));
  endtask

  task automatic spot(input string name, input int inst, input exp_t e);
    @(posedge clk);
    #1;
    if (inst == 0) cmp(name, {d4, c4, v4, a4}, e);
    else           cmp(name, {d3, c3, v3, a3}, e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q4.size() > 0) begin
        e = q4.pop_front();
        cmp("sb4", {d4, c4, v4, a4}, e);
      end
      if (q3.size() > 0) begin
        e = q3.pop_front();
        cmp("sb3", {d3, c3, v3, a3}, e);
      end
    end
  end

  initial begin : stim
    logic [31:0] dat;
    logic [3:0]  val;
    bit          am_r;
    int          thr;
    int seq[35] = '{0,0,0,0,1,1,1,1,3,3,3,3,0,0,0,0,1,1,1,1,3,3,3,3,
                    0,0,1,1,1,1,3,3,3,3,0};

    dat = 32'h80_22_11_05;
    drive(1, 0, 0, 0, 16, 4'hF, dat);
    drive(1, 0, 0, 0, 16, 4'hF, dat);
    spot("reset", 0, '0);

    dat = 32'h80_37_11_05;
    drive(0, 0, 2, 0, 16, 4'hF, dat);
    spot("manual_sel2", 0, '{d: 8'h37, ch: 2'd2, v: 1'b1, a: 1'b0});

    dat = 32'h80_22_11_05;
    drive(0, 0, 0, 0, 16, 4'hF, dat);
    for (int c = 0; c < 35; c++) begin
      drive(0, 1, 0, (c == 26 || c == 34), 16, 4'b1011, dat);
      spot($sformatf("scroll_c%0d", c), 0,
           '{d: 8'(byte_of(dat, seq[c])), ch: 2'(seq[c]), v: 1'b1, a: 1'b0});
    end

    drive(0, 1, 0, 1, 16, 4'b1011, dat);
    spot("pulse_to_ch1", 0, '{d: 8'h11, ch: 2'd1, v: 1'b1, a: 1'b0});
    dat = 32'h0C_22_11_05;
    drive(0, 1, 0, 0, 16, 4'b1011, dat);
    spot("alert_filter1", 0, '{d: 8'h11, ch: 2'd1, v: 1'b1, a: 1'b0});
    drive(0, 1, 0, 0, 16, 4'b1011, dat);
    spot("alert_raise", 0, '{d: 8'h0C, ch: 2'd3, v: 1'b1, a: 1'b1});
    drive(0, 1, 0, 1, 16, 4'b1011, dat);
    spot("alert_hold", 0, '{d: 8'h0C, ch: 2'd3, v: 1'b1, a: 1'b1});
    dat = 32'h10_22_11_05;
    for (int c = 0; c < 4; c++) begin
      drive(0, 1, 0, 0, 16, 4'b1011, dat);
      spot($sformatf("alert_exit_%0d", c), 0, '{d: 8'h11, ch: 2'd1, v: 1'b1, a: 1'b0});
    end
    drive(0, 1, 0, 0, 16, 4'b1011, 32'h0C_22_11_05);
    spot("dip_once", 0, '{d: 8'h0C, ch: 2'd3, v: 1'b1, a: 1'b0});
    drive(0, 1, 0, 0, 16, 4'b1011, 32'h80_22_11_05);
    spot("dip_recover", 0, '{d: 8'h80, ch: 2'd3, v: 1'b1, a: 1'b0});

    for (int c = 0; c < 6; c++) begin
      drive(0, 1, 0, (c == 2), 16, 4'b0000, 32'h80_22_11_05);
      spot($sformatf("none_valid_%0d", c), 0, '{d: 8'h80, ch: 2'd3, v: 1'b0, a: 1'b0});
    end

    drive(0, 0, 3, 0, 16, 4'hF, 32'h80_22_11_05);
    spot("nch3_sel3", 1, '{d: 8'h00, ch: 2'd3, v: 1'b0, a: 1'b0});

    drive(0, 1, 3, 0, 16, 4'hF, 32'h0C_22_11_05);
    drive(0, 1, 3, 0, 16, 4'hF, 32'h0C_22_11_05);
    spot("alert_before_rst", 0, '{d: 8'h0C, ch: 2'd3, v: 1'b1, a: 1'b1});
    drive(1, 1, 3, 0, 16, 4'hF, 32'h0C_22_11_05);
    spot("rst_in_alert", 0, '0);

    am_r = 1'b0;
    thr  = 16;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 29) == 0) am_r = ~am_r;
      if ($urandom_range(0, 199) == 0) thr = int'($urandom_range(12, 20));
      dat = $urandom;
      dat[31:24] = 8'($urandom_range(8, 24));
      if ($urandom_range(0, 1) == 0) dat[23:16] = 8'($urandom_range(8, 24));
      for (int k = 0; k < 4; k++) val[k] = ($urandom_range(0, 4) != 0);
      drive(($urandom_range(0, 149) == 0), am_r, int'($urandom_range(0, 3)),
            ($urandom_range(0, 5) == 0), thr, val, dat);
    end

    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (q4.size() + q3.size() != 0) begin
      n_err++;
      $display("FAIL drain got %0d pending required 0", q4.size() + q3.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
